// File: rtl/alu_fpga_sequencer.sv
// Push-button operand sequencer for a combinational ALU; optional BTN_DEBOUNCE_EN filters the button.
// Latency: 3 cycles btn->update (2+DEB_CYC+1 with debounce); no backpressure, one step per clean press.
module alu_fpga_sequencer #(
    parameter  int SW_W    = 16,
    parameter  int DATA_W  = 32,
    parameter  int FUNCT_W = 4,
    parameter  int DEB_CYC = 8,
    localparam int N       = DATA_W / SW_W,
    localparam int NSTEP   = 3 * N + 2,
    localparam int STEP_W  = $clog2(NSTEP)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn,
    input  logic [SW_W-1:0]    switch,
    input  logic [DATA_W-1:0]  alu_s,
    input  logic               alu_z,
    output logic [DATA_W-1:0]  a,
    output logic [DATA_W-1:0]  b,
    output logic [FUNCT_W-1:0] funct,
    output logic [SW_W-1:0]    out,
    output logic [STEP_W-1:0]  step
);

    if ((DATA_W % SW_W) != 0 || FUNCT_W > SW_W) begin : g_param_check
        $error("alu_fpga_sequencer: DATA_W must be a multiple of SW_W and FUNCT_W <= SW_W");
    end

    localparam logic [STEP_W-1:0] S_2N  = STEP_W'(2 * N);
    localparam logic [STEP_W-1:0] S_3N1 = STEP_W'(3 * N + 1);

    logic [1:0] sync;
    logic       lvl;
    logic       lvl_prev;
    logic       press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], btn};
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYC + 1);
    logic [CNT_W-1:0] deb_cnt;
    logic             filt;

    // The filtered level only flips after DEB_CYC consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt <= '0;
            filt    <= 1'b0;
        end else if (sync[1] != filt) begin
            if (deb_cnt == CNT_W'(DEB_CYC - 1)) begin
                filt    <= sync[1];
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    assign lvl = filt;
`else
    assign lvl = sync[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_prev <= 1'b0;
        end else begin
            lvl_prev <= lvl;
        end
    end

    assign press = lvl & ~lvl_prev;

    logic [STEP_W-1:0] step_nxt;

    always_comb begin
        step_nxt = step + STEP_W'(1);
        // Last phase wraps; anything beyond it is corrupt state and also returns to 0.
        if (step >= S_3N1) begin
            step_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a     <= '0;
            b     <= '0;
            funct <= '0;
            out   <= '0;
            step  <= '0;
        end else if (press) begin
            step <= step_nxt;
            for (int i = 0; i < N; i++) begin
                if (step == STEP_W'(i)) begin
                    a[i*SW_W +: SW_W] <= switch;
                end
                if (step == STEP_W'(N + i)) begin
                    b[i*SW_W +: SW_W] <= switch;
                end
                if (step == STEP_W'(2 * N + 1 + i)) begin
                    out <= alu_s[i*SW_W +: SW_W];
                end
            end
            if (step == S_2N) begin
                funct <= switch[FUNCT_W-1:0];
            end
            if (step == S_3N1) begin
                out <= {{(SW_W-1){1'b0}}, alu_z};
            end
        end
    end

endmodule

// File: tb/tb_alu_fpga_sequencer.sv
// Bench for alu_fpga_sequencer with a stub adder ALU: fixed vector table, corner sequences, random presses.
module tb_alu_fpga_sequencer;
    localparam int SW_W    = 16;
    localparam int DATA_W  = 32;
    localparam int FUNCT_W = 4;
    localparam int DEB_CYC = 8;
`ifdef BTN_DEBOUNCE_EN
    localparam int LAT = 2 + DEB_CYC + 1;
    localparam bit DEB = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit DEB = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               btn;
    logic [SW_W-1:0]    switch;
    logic [DATA_W-1:0]  alu_s;
    logic               alu_z;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [FUNCT_W-1:0] funct;
    logic [SW_W-1:0]    out;
    logic [2:0]         step;

    alu_fpga_sequencer #(
        .SW_W(SW_W), .DATA_W(DATA_W), .FUNCT_W(FUNCT_W), .DEB_CYC(DEB_CYC)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .switch(switch),
        .alu_s(alu_s), .alu_z(alu_z),
        .a(a), .b(b), .funct(funct), .out(out), .step(step)
    );

    assign alu_s = a + b;
    assign alu_z = (alu_s == '0);

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: operands as whole words, phase as a plain integer.
    logic [31:0] m_a, m_b;
    logic [3:0]  m_f;
    logic [15:0] m_out;
    int          m_step;

    typedef struct {
        logic [15:0] sw;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [3:0]  ef;
        logic [15:0] eo;
        int          est;
    } vec_t;
    vec_t tbl[24];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm);
        chk({nm, ".a"}, a, m_a);
        chk({nm, ".b"}, b, m_b);
        chk({nm, ".funct"}, 32'(funct), 32'(m_f));
        chk({nm, ".out"}, 32'(out), 32'(m_out));
        chk({nm, ".step"}, 32'(step), 32'(m_step));
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0; m_f = '0; m_out = '0; m_step = 0;
    endtask

    task automatic model_press(input logic [15:0] sw);
        logic [31:0] s;
        int k;
        k = m_step;
        s = m_a + m_b;
        if (k <= 1)
            m_a = (m_a & ~(32'hFFFF << (16 * k))) | ({16'h0, sw} << (16 * k));
        else if (k <= 3)
            m_b = (m_b & ~(32'hFFFF << (16 * (k - 2)))) | ({16'h0, sw} << (16 * (k - 2)));
        else if (k == 4)
            m_f = sw[3:0];
        else if (k <= 6)
            m_out = 16'(s >> (16 * (k - 5)));
        else
            m_out = (s == 0) ? 16'd1 : 16'd0;
        m_step = (k + 1) % 8;
    endtask

    task automatic press(input logic [15:0] sw, input int hi, input int lo);
        @(negedge clk);
        switch = sw;
        btn = 1'b1;
        repeat (hi) @(negedge clk);
        btn = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic do_press(input logic [15:0] sw);
        press(sw, 12, 14);
        model_press(sw);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_all({nm, ".async"});
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_all({nm, ".after"});
    endtask

    task automatic setv(input int i, input logic [15:0] sw, input logic [31:0] ea,
                        input logic [31:0] eb, input logic [3:0] ef, input logic [15:0] eo,
                        input int est);
        tbl[i].sw = sw; tbl[i].ea = ea; tbl[i].eb = eb;
        tbl[i].ef = ef; tbl[i].eo = eo; tbl[i].est = est;
    endtask

    initial begin
        int cnt;
        logic [15:0] sw;
        setv(0,  16'h5678, 32'h00005678, 32'h0, 4'h0, 16'h0000, 1);
        setv(1,  16'h1234, 32'h12345678, 32'h0, 4'h0, 16'h0000, 2);
        setv(2,  16'h0001, 32'h12345678, 32'h1, 4'h0, 16'h0000, 3);
        setv(3,  16'h0000, 32'h12345678, 32'h1, 4'h0, 16'h0000, 4);
        setv(4,  16'hFFF3, 32'h12345678, 32'h1, 4'h3, 16'h0000, 5);
        setv(5,  16'h0000, 32'h12345678, 32'h1, 4'h3, 16'h5679, 6);
        setv(6,  16'h0000, 32'h12345678, 32'h1, 4'h3, 16'h1234, 7);
        setv(7,  16'h0000, 32'h12345678, 32'h1, 4'h3, 16'h0000, 0);
        setv(8,  16'hFFFF, 32'h1234FFFF, 32'h1, 4'h3, 16'h0000, 1);
        setv(9,  16'h0000, 32'h0000FFFF, 32'h1, 4'h3, 16'h0000, 2);
        setv(10, 16'h0001, 32'h0000FFFF, 32'h1, 4'h3, 16'h0000, 3);
        setv(11, 16'h0000, 32'h0000FFFF, 32'h1, 4'h3, 16'h0000, 4);
        setv(12, 16'hFFF3, 32'h0000FFFF, 32'h1, 4'h3, 16'h0000, 5);
        setv(13, 16'h0000, 32'h0000FFFF, 32'h1, 4'h3, 16'h0000, 6);
        setv(14, 16'h0000, 32'h0000FFFF, 32'h1, 4'h3, 16'h0001, 7);
        setv(15, 16'h0000, 32'h0000FFFF, 32'h1, 4'h3, 16'h0000, 0);
        setv(16, 16'hFFFF, 32'h0000FFFF, 32'h1, 4'h3, 16'h0000, 1);
        setv(17, 16'hFFFF, 32'hFFFFFFFF, 32'h1, 4'h3, 16'h0000, 2);
        setv(18, 16'h0001, 32'hFFFFFFFF, 32'h1, 4'h3, 16'h0000, 3);
        setv(19, 16'h0000, 32'hFFFFFFFF, 32'h1, 4'h3, 16'h0000, 4);
        setv(20, 16'h0000, 32'hFFFFFFFF, 32'h1, 4'h0, 16'h0000, 5);
        setv(21, 16'h0000, 32'hFFFFFFFF, 32'h1, 4'h0, 16'h0000, 6);
        setv(22, 16'h0000, 32'hFFFFFFFF, 32'h1, 4'h0, 16'h0000, 7);
        setv(23, 16'h0000, 32'hFFFFFFFF, 32'h1, 4'h0, 16'h0001, 0);

        rst = 1'b1; btn = 1'b0; switch = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_all("reset_held");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset_released");

        // First-press latency, counted in posedges from the btn rise.
        @(negedge clk);
        switch = 16'h5678;
        btn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            cnt++;
            #1;
            if (step != 3'd0) break;
        end
        chk("latency", cnt, LAT);
        repeat (12) @(negedge clk);
        btn = 1'b0;
        repeat (14) @(negedge clk);
        model_press(16'h5678);
        chk_all("latency_state");
        do_reset("reset_mid");

        for (int i = 0; i < 24; i++) begin
            press(tbl[i].sw, 12, 14);
            model_press(tbl[i].sw);
            chk($sformatf("tbl%0d.a", i), a, tbl[i].ea);
            chk($sformatf("tbl%0d.b", i), b, tbl[i].eb);
            chk($sformatf("tbl%0d.funct", i), 32'(funct), 32'(tbl[i].ef));
            chk($sformatf("tbl%0d.out", i), 32'(out), 32'(tbl[i].eo));
            chk($sformatf("tbl%0d.step", i), 32'(step), tbl[i].est);
        end

        press(16'hABCD, 200, 14);
        model_press(16'hABCD);
        chk_all("hold200");

        press(16'h4444, 5, 20);
        if (!DEB) model_press(16'h4444);
        chk_all("glitch5");

        do_press(16'h2222);
        chk_all("press12");

        for (int i = 0; i < 40; i++) begin
            sw = 16'($urandom);
            press(sw, 10 + int'($urandom_range(0, 5)), 12 + int'($urandom_range(0, 5)));
            model_press(sw);
            chk_all($sformatf("rnd%0d", i));
        end

        while (m_step != 0) do_press(16'($urandom));
        repeat (3) do_press(16'($urandom));
        chk("pass2_step", 32'(step), 32'd3);
        do_reset("reset_step3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
